cpl_unit: RTL and testbench

Privilege-level controller sitting between the commit stage and the I/O unit. It owns the current privilege level (CPL) and sequences privilege transitions through a fixed-latency recompute window. It also issues retired I/O ops to the I/O unit as single-cycle retire pulses. The I/O unit consumes `cpl_o`, `cpl_recompute_o`, `io_retire_o` and `io_op_o` directly.

---
 rtl/cpl_unit.sv | 103 ++++++++++
 tb/tb_cpl_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpl_unit.sv
// rtl/cpl_unit.sv - privilege-level controller between commit and the I/O unit
package cpl_pkg;
    typedef logic [7:0] op_t;
    localparam op_t OPC_NOP     = 8'h00;
    localparam op_t OPC_WELCOME = 8'h57;
endpackage

module cpl_unit
    import cpl_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int RECOMPUTE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic retire_valid_i,
    output logic retire_ready_o,
    input  op_t  retire_op_i,
    input  logic retire_is_io_i,
    input  logic retire_is_cpl_i,
    input  logic cpl_target_i,
    input  logic gate_ok_i,
    output logic cpl_o,
    output logic cpl_recompute_o,
    output logic io_retire_o,
    output op_t  io_op_o,
    input  logic io_done_i,
    output logic fault_o
);

    typedef enum logic [1:0] {IDLE, RECOMP, IO_ISSUE, IO_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(RECOMPUTE_LAT - 1);

    if (DATA_WIDTH < 1 || RECOMPUTE_LAT < 1 || RECOMPUTE_LAT > 15) begin : g_param_check
        $error("cpl_unit: illegal parameter value");
    end

    state_t     state;
    logic       pending;
    logic [3:0] cnt;

    // Ready depends only on the state register, never on this cycle's inputs.
    assign retire_ready_o = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cpl_o           <= 1'b1;
            pending         <= 1'b1;
            cnt             <= 4'd0;
            cpl_recompute_o <= 1'b0;
            io_retire_o     <= 1'b0;
            io_op_o         <= OPC_NOP;
            fault_o         <= 1'b0;
        end else begin
            fault_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (retire_valid_i) begin
                        if (retire_is_io_i && retire_is_cpl_i) begin
                            fault_o <= 1'b1;
                        end else if (retire_is_cpl_i) begin
                            // USER->SUPERVISOR is only allowed through a syscall gate.
                            if (!cpl_o && cpl_target_i && !gate_ok_i) begin
                                fault_o <= 1'b1;
                            end else begin
                                pending         <= cpl_target_i;
                                cnt             <= LAT_M1;
                                cpl_recompute_o <= 1'b1;
                                state           <= RECOMP;
                            end
                        end else if (retire_is_io_i) begin
                            io_op_o     <= retire_op_i;
                            io_retire_o <= 1'b1;
                            state       <= IO_ISSUE;
                        end
                    end
                end
                RECOMP: begin
                    if (cnt == 4'd0) begin
                        cpl_o           <= pending;
                        cpl_recompute_o <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                IO_ISSUE: begin
                    io_retire_o <= 1'b0;
                    state       <= io_done_i ? IDLE : IO_WAIT;
                end
                IO_WAIT: begin
                    if (io_done_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpl_unit.sv
// tb/tb_cpl_unit.sv - scoreboard bench for cpl_unit with randomized retire traffic
module tb_cpl_unit;
    import cpl_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic retire_valid_i = 1'b0;
    logic retire_ready_o;
    op_t  retire_op_i = OPC_NOP;
    logic retire_is_io_i = 1'b0;
    logic retire_is_cpl_i = 1'b0;
    logic cpl_target_i = 1'b0;
    logic gate_ok_i = 1'b0;
    logic cpl_o;
    logic cpl_recompute_o;
    logic io_retire_o;
    op_t  io_op_o;
    logic io_done_i = 1'b0;
    logic fault_o;

    cpl_unit #(.DATA_WIDTH(64), .RECOMPUTE_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .retire_valid_i(retire_valid_i),
        .retire_ready_o(retire_ready_o),
        .retire_op_i(retire_op_i),
        .retire_is_io_i(retire_is_io_i),
        .retire_is_cpl_i(retire_is_cpl_i),
        .cpl_target_i(cpl_target_i),
        .gate_ok_i(gate_ok_i),
        .cpl_o(cpl_o),
        .cpl_recompute_o(cpl_recompute_o),
        .io_retire_o(io_retire_o),
        .io_op_o(io_op_o),
        .io_done_i(io_done_i),
        .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass = 0;
    op_t exp_io_op[$];
    bit  exp_io_cpl[$];
    bit  exp_cpl[$];
    int  exp_faults = 0;
    bit  mon_en = 1'b0;
    bit  model_cpl = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse or ends a transition.
    int run = 0;
    bit prev_rc = 1'b0;
    bit prev_io = 1'b0;
    always @(negedge clk) begin
        if (!mon_en) begin
            run = 0;
            prev_rc = 1'b0;
            prev_io = 1'b0;
        end else begin
            if (cpl_recompute_o) begin
                run++;
            end else if (prev_rc) begin
                chk("recompute_len", 64'(run), 64'(LAT));
                chk("cpl_expected", 64'(exp_cpl.size() > 0), 64'(1));
                if (exp_cpl.size() > 0) chk("cpl_after_recompute", 64'(cpl_o), 64'(exp_cpl.pop_front()));
                run = 0;
            end
            if (io_retire_o) begin
                chk("io_single_pulse", 64'(prev_io), 64'(0));
                chk("io_expected", 64'(exp_io_op.size() > 0), 64'(1));
                if (exp_io_op.size() > 0) begin
                    chk("io_op", 64'(io_op_o), 64'(exp_io_op.pop_front()));
                    chk("io_cpl", 64'(cpl_o), 64'(exp_io_cpl.pop_front()));
                end
            end
            if (fault_o) begin
                chk("fault_expected", 64'(exp_faults > 0), 64'(1));
                if (exp_faults > 0) exp_faults--;
            end
            prev_rc = cpl_recompute_o;
            prev_io = io_retire_o;
        end
    end

    // kind: 0 = no effect, 1 = fault, 2 = privilege change, 3 = I/O
    task automatic issue(input op_t op, input bit io, input bit cp, input bit tgt,
                         input bit gate, input int d);
        int kind;
        int exp_lat;
        int n;
        int cycles;
        if (io && cp) kind = 1;
        else if (cp && !model_cpl && tgt && !gate) kind = 1;
        else if (cp) kind = 2;
        else if (io) kind = 3;
        else kind = 0;
        exp_lat = (kind == 2) ? LAT + 1 : (kind == 3) ? 2 + d : 1;
        @(negedge clk);
        n = 0;
        while (!retire_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 64'(retire_ready_o), 64'(1));
        case (kind)
            1: exp_faults++;
            2: begin exp_cpl.push_back(tgt); model_cpl = tgt; end
            3: begin exp_io_op.push_back(op); exp_io_cpl.push_back(model_cpl); end
            default: ;
        endcase
        retire_op_i = op;
        retire_is_io_i = io;
        retire_is_cpl_i = cp;
        cpl_target_i = tgt;
        gate_ok_i = gate;
        io_done_i = 1'b0;
        retire_valid_i = 1'b1;
        @(posedge clk);
        cycles = 0;
        do begin
            @(negedge clk);
            retire_valid_i = 1'b0;
            if (cycles == 0) begin
                chk("fault_next_cycle", 64'(fault_o), 64'(kind == 1));
                chk("io_pulse_next_cycle", 64'(io_retire_o), 64'(kind == 3));
                chk("recompute_next_cycle", 64'(cpl_recompute_o), 64'(kind == 2));
            end
            io_done_i = (cycles >= d);
            cycles++;
        end while (!retire_ready_o && cycles < 200);
        chk("ready_latency", 64'(cycles), 64'(exp_lat));
        if (kind == 3) chk("io_op_held", 64'(io_op_o), 64'(op));
        chk("cpl_level", 64'(cpl_o), 64'(model_cpl));
        io_done_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int pulses;
        bit saw;
        op_t op;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(retire_ready_o), 64'(1));
        chk("rst_cpl", 64'(cpl_o), 64'(1));
        chk("rst_recompute", 64'(cpl_recompute_o), 64'(0));
        chk("rst_io_retire", 64'(io_retire_o), 64'(0));
        chk("rst_io_op", 64'(io_op_o), 64'(0));
        chk("rst_fault", 64'(fault_o), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(retire_ready_o), 64'(1));
        chk("post_rst_cpl", 64'(cpl_o), 64'(1));
        mon_en = 1'b1;

        issue(OPC_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 0);          // drop to USER
        issue(OPC_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 0);          // illegal elevation
        issue(OPC_NOP, 1'b0, 1'b1, 1'b1, 1'b1, 0);          // gated elevation
        issue(OPC_WELCOME, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        issue(8'h3c, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        issue(8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 0);            // both flags
        issue(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 0);            // plain retire
        issue(OPC_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 0);          // same-level still recomputes

        // Backpressure: io op held valid through the recompute window.
        @(negedge clk);
        exp_cpl.push_back(1'b0);
        model_cpl = 1'b0;
        retire_is_cpl_i = 1'b1;
        retire_is_io_i = 1'b0;
        cpl_target_i = 1'b0;
        retire_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 8'ha5;
        exp_io_op.push_back(op);
        exp_io_cpl.push_back(1'b0);
        retire_op_i = op;
        retire_is_cpl_i = 1'b0;
        retire_is_io_i = 1'b1;
        io_done_i = 1'b1;
        cyc = 1;
        while (!io_retire_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        retire_valid_i = 1'b0;
        chk("backpressure_pulse_cycle", 64'(cyc), 64'(LAT + 2));
        @(negedge clk);
        chk("backpressure_ready", 64'(retire_ready_o), 64'(1));
        io_done_i = 1'b0;

        for (int i = 0; i < 60; i++) begin
            issue(op_t'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 4)));
        end

        // Reset in the second recompute cycle.
        mon_en = 1'b0;
        @(negedge clk);
        retire_is_cpl_i = 1'b1;
        retire_is_io_i = 1'b0;
        cpl_target_i = 1'b0;
        retire_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        retire_valid_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cpl", 64'(cpl_o), 64'(1));
        chk("async_rst_recompute", 64'(cpl_recompute_o), 64'(0));
        chk("async_rst_ready", 64'(retire_ready_o), 64'(1));
        chk("async_rst_io_op", 64'(io_op_o), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (cpl_recompute_o || !cpl_o) saw = 1'b1;
        end
        chk("no_transition_after_reset", 64'(saw), 64'(0));
        model_cpl = 1'b1;
        exp_cpl.delete();
        exp_io_op.delete();
        exp_io_cpl.delete();
        exp_faults = 0;
        mon_en = 1'b1;

        // Reset while waiting on io_done.
        @(negedge clk);
        op = 8'h5a;
        exp_io_op.push_back(op);
        exp_io_cpl.push_back(model_cpl);
        retire_op_i = op;
        retire_is_io_i = 1'b1;
        retire_is_cpl_i = 1'b0;
        io_done_i = 1'b0;
        retire_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        retire_valid_i = 1'b0;
        @(negedge clk);
        chk("io_wait_not_ready", 64'(retire_ready_o), 64'(0));
        #2 rst = 1'b0;
        #1;
        chk("io_wait_rst_ready", 64'(retire_ready_o), 64'(1));
        chk("io_wait_rst_pulse", 64'(io_retire_o), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (io_retire_o) pulses++;
        end
        chk("no_pulse_after_reset", 64'(pulses), 64'(0));

        issue(OPC_WELCOME, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        chk("io_queue_drained", 64'(exp_io_op.size()), 64'(0));
        chk("cpl_queue_drained", 64'(exp_cpl.size()), 64'(0));
        chk("faults_drained", 64'(exp_faults), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
